// File: rtl/sd_block_writer.sv
// SPI-mode SD single-block writer: CMD24, 512 data bytes from sector RAM, data response, busy wait.
// Define SD_WR_CRC16_EN to send a CRC16-CCITT over the block; otherwise the CRC bytes are 0xFF 0xFF.
module sd_block_writer #(
  parameter int CLK_DIV     = 2,
  parameter int R1_POLL_MAX = 8,
  parameter int BUSY_MAX    = 65535
) (
  input  logic        clock_50r,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] block_addr,
  output logic        data_rd,
  output logic [8:0]  data_addr,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_code,
  output logic        SD_CS,
  output logic        SD_CLK,
  output logic        SD_OUT,
  input  logic        SD_IN
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC,
    S_DRESP, S_BUSY, S_FIN, S_END, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      addr;
  logic [DIV_W-1:0] div;
  logic [2:0]       bit_cnt;
  logic [9:0]       byte_cnt, byte_cnt_nx;
  logic [15:0]      busy_cnt;
  logic [7:0]       tx_sh, rx_sh, dbuf, tx_nx;
  logic             rd_q, accept, byte_done, fail;
  logic [2:0]       fail_code;
`ifdef SD_WR_CRC16_EN
  logic [15:0]      crc;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction
`endif

  function automatic logic is_run(input state_t s);
    return s inside {S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC, S_DRESP, S_BUSY, S_FIN};
  endfunction

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign byte_done = is_run(state) && SD_CLK && (div == DIV_W'(CLK_DIV - 1)) && (bit_cnt == 3'd7);

  always_ff @(posedge clock_50r) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    fail        = 1'b0;
    fail_code   = 3'd0;
    if (accept) begin
      state_nx    = S_CMD;
      byte_cnt_nx = 10'd0;
    end else if (state == S_END) begin
      state_nx = S_DONE;
    end else if (state == S_DONE) begin
      state_nx = S_IDLE;
    end else if (byte_done) begin
      byte_cnt_nx = byte_cnt + 10'd1;
      case (state)
        S_CMD:   if (byte_cnt == 10'd5) state_nx = S_R1;
        S_R1:
          if (rx_sh != 8'hFF) begin
            if (rx_sh == 8'h00) state_nx = S_GAP;
            else begin fail = 1'b1; fail_code = 3'd2; end
          end else if (byte_cnt == 10'(R1_POLL_MAX - 1)) begin
            fail = 1'b1; fail_code = 3'd1;
          end
        S_GAP:   state_nx = S_TOKEN;
        S_TOKEN: state_nx = S_DATA;
        S_DATA:  if (byte_cnt == 10'd511) state_nx = S_CRC;
        S_CRC:   if (byte_cnt == 10'd1) state_nx = S_DRESP;
        S_DRESP:
          if (rx_sh != 8'hFF) begin
            if (rx_sh[4:0] == 5'h05) state_nx = S_BUSY;
            else begin fail = 1'b1; fail_code = 3'd3; end
          end else if (byte_cnt == 10'(R1_POLL_MAX - 1)) begin
            fail = 1'b1; fail_code = 3'd3;
          end
        S_BUSY:
          if (rx_sh == 8'hFF) state_nx = S_FIN;
          else if (busy_cnt == 16'(BUSY_MAX - 1)) begin fail = 1'b1; fail_code = 3'd4; end
        S_FIN:   state_nx = S_END;
        default: ;
      endcase
      if (fail) state_nx = S_FIN;
      if (state_nx != state) byte_cnt_nx = 10'd0;
    end
  end

  always_comb begin
    SD_CS = 1'b1;
    busy  = 1'b1;
    done  = 1'b0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_DONE: begin busy = 1'b0; done = 1'b1; end
      S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC, S_DRESP, S_BUSY: SD_CS = 1'b0;
      default: ;
    endcase
  end

  // Byte chosen for the slot that starts when state_nx/byte_cnt_nx take effect
  always_comb begin
    tx_nx = 8'hFF;
    case (state_nx)
      S_CMD:
        case (byte_cnt_nx)
          10'd0:   tx_nx = 8'h58;
          10'd1:   tx_nx = addr[31:24];
          10'd2:   tx_nx = addr[23:16];
          10'd3:   tx_nx = addr[15:8];
          10'd4:   tx_nx = addr[7:0];
          default: tx_nx = 8'hFF;
        endcase
      S_TOKEN: tx_nx = 8'hFE;
      S_DATA:  tx_nx = dbuf;
`ifdef SD_WR_CRC16_EN
      S_CRC:   tx_nx = (byte_cnt_nx == 10'd0) ? crc[15:8] : crc[7:0];
`endif
      default: tx_nx = 8'hFF;
    endcase
  end

  always_ff @(posedge clock_50r) begin
    if (reset) begin
      byte_cnt <= 10'd0;
      busy_cnt <= 16'd0;
      err_code <= 3'd0;
    end else begin
      byte_cnt <= byte_cnt_nx;
      if (accept) begin
        busy_cnt <= 16'd0;
        err_code <= 3'd0;
      end else begin
        if (byte_done && state == S_BUSY && rx_sh != 8'hFF && busy_cnt != 16'hFFFF)
          busy_cnt <= busy_cnt + 16'd1;
        if (fail) err_code <= fail_code;
      end
    end
  end

  always_ff @(posedge clock_50r) begin
    if (accept) addr <= block_addr;
    if (rd_q)   dbuf <= data_in;
  end

  // SPI mode 0 shifter: MOSI changes while SCK is low, MISO sampled on the rising edge
  always_ff @(posedge clock_50r) begin
    if (reset) begin
      SD_CLK  <= 1'b0;
      SD_OUT  <= 1'b1;
      div     <= '0;
      bit_cnt <= 3'd0;
    end else if (accept || (byte_done && is_run(state_nx))) begin
      tx_sh   <= tx_nx;
      SD_OUT  <= tx_nx[7];
      SD_CLK  <= 1'b0;
      div     <= '0;
      bit_cnt <= 3'd0;
    end else if (!is_run(state)) begin
      SD_CLK  <= 1'b0;
      SD_OUT  <= 1'b1;
      div     <= '0;
      bit_cnt <= 3'd0;
    end else if (div == DIV_W'(CLK_DIV - 1)) begin
      div <= '0;
      if (!SD_CLK) begin
        SD_CLK <= 1'b1;
        rx_sh  <= {rx_sh[6:0], SD_IN};
      end else begin
        SD_CLK  <= 1'b0;
        bit_cnt <= bit_cnt + 3'd1;
        tx_sh   <= {tx_sh[6:0], 1'b1};
        SD_OUT  <= tx_sh[6];
      end
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Prefetch one byte ahead: index n is strobed when byte n-1 is loaded into the shifter
  always_ff @(posedge clock_50r) begin
    if (reset) begin
      data_rd   <= 1'b0;
      data_addr <= 9'd0;
      rd_q      <= 1'b0;
    end else begin
      data_rd <= 1'b0;
      rd_q    <= data_rd;
      if (accept) begin
        data_addr <= 9'd0;
      end else if (byte_done && state == S_GAP) begin
        data_rd   <= 1'b1;
        data_addr <= 9'd0;
      end else if (byte_done && (state == S_TOKEN || (state == S_DATA && byte_cnt < 10'd510))) begin
        data_rd   <= 1'b1;
        data_addr <= data_addr + 9'd1;
      end
    end
  end

`ifdef SD_WR_CRC16_EN
  always_ff @(posedge clock_50r) begin
    if (accept)                             crc <= 16'h0000;
    else if (byte_done && state_nx == S_DATA) crc <= crc16_step(crc, tx_nx);
  end
`endif

endmodule

// File: tb/tb_sd_block_writer.sv
// Scoreboard bench for sd_block_writer: MOSI bytes and completion records are queued by the
// stimulus and checked by independent card and done monitors.
`timescale 1ns/1ps
module tb_sd_block_writer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] block_addr = '0;
  logic        data_rd;
  logic [8:0]  data_addr;
  logic [7:0]  data_in = 8'h00;
  logic        busy, done;
  logic [2:0]  err_code;
  logic        sd_cs, sd_clk, sd_out;
  logic        miso = 1'b1;

  sd_block_writer #(.CLK_DIV(1), .R1_POLL_MAX(8), .BUSY_MAX(4)) dut (
    .clock_50r(clk), .reset(reset), .start(start), .block_addr(block_addr),
    .data_rd(data_rd), .data_addr(data_addr), .data_in(data_in),
    .busy(busy), .done(done), .err_code(err_code),
    .SD_CS(sd_cs), .SD_CLK(sd_clk), .SD_OUT(sd_out), .SD_IN(miso));

  always #5 clk = ~clk;

`ifdef SD_WR_CRC16_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef struct { logic [2:0] err; int nrd; } done_t;
  logic [7:0] exp_mosi[$];
  done_t      exp_done[$];
  int n_tests = 0, n_fail = 0, n_done = 0;
  int cyc = 0, last_fall = 0, rd_cnt = 0;
  logic [8:0] first_addr = '0;

  logic [7:0] ram [512];
  always @(posedge clk) if (data_rd) data_in <= ram[data_addr];
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Card model: R1 at slot 6, data response at slot 523, then busy_n busy bytes
  logic [7:0] r1_val = 8'h00, dresp_val = 8'h05;
  int busy_n = 3, slot = 0, bitn = 0;
  logic [7:0] out_byte = 8'hFF, in_byte = 8'hFF, got;
  logic clk_q = 1'b0, cs_q = 1'b1;

  function automatic logic [7:0] card_byte(input int s);
    if (s == 6) return r1_val;
    if (s == 523) return dresp_val;
    if (s >= 524 && s < 524 + busy_n) return 8'h00;
    return 8'hFF;
  endfunction

  always @(sd_clk or sd_cs) begin
    if (cs_q && !sd_cs) begin
      slot = 0; bitn = 0; out_byte = card_byte(0); miso = out_byte[7];
    end
    if (!clk_q && sd_clk) begin
      in_byte = {in_byte[6:0], sd_out};
      bitn++;
      if (bitn == 8) begin
        bitn = 0;
        if (!sd_cs) slot++;
        check("mosi_expected", exp_mosi.size() != 0, 1);
        if (exp_mosi.size() != 0) begin
          got = exp_mosi.pop_front();
          check("mosi_byte", in_byte, got);
        end
      end
    end
    if (clk_q && !sd_clk) begin
      last_fall = cyc;
      if (bitn == 0) out_byte = card_byte(slot);
      miso = sd_cs ? 1'b1 : out_byte[7 - bitn];
    end
    clk_q = sd_clk;
    cs_q  = sd_cs;
  end

  always @(negedge clk) begin
    done_t e;
    if (start && !busy) rd_cnt = 0;
    if (data_rd) begin
      if (rd_cnt == 0) first_addr = data_addr;
      rd_cnt++;
    end
    if (done) begin
      n_done++;
      check("done_expected", exp_done.size() != 0, 1);
      if (exp_done.size() != 0) begin
        e = exp_done.pop_front();
        check("err_code", err_code, e.err);
        check("data_rd_count", rd_cnt, e.nrd);
        if (e.nrd != 0) check("first_data_addr", first_addr, 0);
        check("cs_at_done", sd_cs, 1);
        check("busy_at_done", busy, 0);
        check("mosi_pending", exp_mosi.size(), 0);
        check("done_latency", cyc - last_fall, 1);
      end
    end
  end

  function automatic logic [15:0] crc_ref();
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < 512; i++) begin
      c = c ^ {ram[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  task automatic push_ff(input int n);
    for (int i = 0; i < n; i++) exp_mosi.push_back(8'hFF);
  endtask

  task automatic push_cmd(input logic [31:0] a);
    exp_mosi.push_back(8'h58);
    exp_mosi.push_back(a[31:24]); exp_mosi.push_back(a[23:16]);
    exp_mosi.push_back(a[15:8]);  exp_mosi.push_back(a[7:0]);
    exp_mosi.push_back(8'hFF);
  endtask

  // R1 poll, gap, token, block, CRC
  task automatic push_body(input logic [15:0] crc);
    push_ff(2);
    exp_mosi.push_back(8'hFE);
    for (int i = 0; i < 512; i++) exp_mosi.push_back(ram[i]);
    exp_mosi.push_back(crc[15:8]);
    exp_mosi.push_back(crc[7:0]);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 512; i++)
      ram[i] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'((i * 13 + 7) ^ (i >> 3));
  endtask

  task automatic do_start(input logic [31:0] a);
    @(posedge clk); #1; block_addr = a; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy_after_start", busy, 1);
    check("cs_after_start", sd_cs, 0);
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [7:0] r1, input logic [7:0] dr,
                         input int bn, input logic [2:0] err, input int nrd, input bit stray);
    done_t e;
    int base, k;
    r1_val = r1; dresp_val = dr; busy_n = bn;
    e.err = err; e.nrd = nrd;
    exp_done.push_back(e);
    base = n_done;
    do_start(a);
    if (stray) begin
      block_addr = 32'hDEADBEEF; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    k = 0;
    while (n_done == base && k < 20000) begin @(posedge clk); #1; k++; end
    check("done_seen", n_done != base, 1);
    repeat (4) @(posedge clk);
    #1 check("err_held", err_code, err);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", sd_cs, 1);      check("rst_clk", sd_clk, 0);
    check("rst_out", sd_out, 1);    check("rst_busy", busy, 0);
    check("rst_done", done, 0);     check("rst_err", err_code, 0);
    check("rst_rd", data_rd, 0);    check("rst_addr", data_addr, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // success, block 0x2000, with a second start ignored while busy
    fill(2);
    push_cmd(32'h0000_2000); push_body(CRC_ON ? crc_ref() : 16'hFFFF); push_ff(6);
    run_txn(32'h0000_2000, 8'h00, 8'h05, 3, 3'd0, 512, 1'b1);

    // all-0xFF block
    fill(1);
    push_cmd(32'h1234_5678); push_body(CRC_ON ? 16'h7FA1 : 16'hFFFF); push_ff(6);
    run_txn(32'h1234_5678, 8'h00, 8'h05, 3, 3'd0, 512, 1'b0);

    // no R1: 8 polls then trailing byte
    push_cmd(32'hA5A5_0001); push_ff(9);
    run_txn(32'hA5A5_0001, 8'hFF, 8'h05, 3, 3'd1, 0, 1'b0);

    // R1 nonzero
    push_cmd(32'h0000_0007); push_ff(2);
    run_txn(32'h0000_0007, 8'h04, 8'h05, 3, 3'd2, 0, 1'b0);

    // all-zero block, data rejected with CRC error response
    fill(0);
    push_cmd(32'h0102_0304); push_body(CRC_ON ? 16'h0000 : 16'hFFFF); push_ff(2);
    run_txn(32'h0102_0304, 8'h00, 8'h0B, 3, 3'd3, 512, 1'b0);

    // busy held past BUSY_MAX=4
    fill(2);
    push_cmd(32'hFFFF_FFFE); push_body(CRC_ON ? crc_ref() : 16'hFFFF); push_ff(6);
    run_txn(32'hFFFF_FFFE, 8'h00, 8'h05, 1000, 3'd4, 512, 1'b0);

    // reset during data byte 100
    r1_val = 8'h00; dresp_val = 8'h05; busy_n = 3;
    push_cmd(32'h0000_0100); push_body(16'hFFFF);
    do_start(32'h0000_0100);
    k = 0;
    while (slot < 109 && k < 5000) begin @(posedge clk); #1; k++; end
    check("reach_byte100", slot >= 109, 1);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_cs", sd_cs, 1);   check("midrst_clk", sd_clk, 0);
    check("midrst_out", sd_out, 1); check("midrst_busy", busy, 0);
    reset = 1'b0;
    exp_mosi.delete();
    exp_done.delete();
    repeat (60) @(posedge clk);
    #1 check("no_done_after_rst", n_done, 6);

    // restart after reset
    push_cmd(32'h0000_0001); push_body(CRC_ON ? crc_ref() : 16'hFFFF); push_ff(6);
    run_txn(32'h0000_0001, 8'h00, 8'h05, 3, 3'd0, 512, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
